// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, control-sequencer states,
// instruction classes and the control-word layout.
package cpu_pkg;

  localparam int unsigned IR_W     = 32;
  localparam int unsigned OPCODE_W = 5;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_BR   = 5'b10010;
  localparam opcode_t OP_JR   = 5'b10011;
  localparam opcode_t OP_IN   = 5'b10101;
  localparam opcode_t OP_OUT  = 5'b10110;
  localparam opcode_t OP_MFHI = 5'b10111;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALT
  } ctrl_state_t;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_ADDI,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_JR,
    CLS_IN,
    CLS_OUT,
    CLS_MFHI,
    CLS_NOP,
    CLS_HALT
  } instr_class_t;

  // At most one of these may be set in any state.
  typedef struct packed {
    logic pc_out;
    logic zhigh_out;
    logic zlow_out;
    logic mdr_out;
    logic hi_out;
    logic lo_out;
    logic inport_out;
    logic c_out;
    logic ba_out;
    logic r_out;
  } bus_drive_t;

  typedef struct packed {
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic pc_in;
    logic r_in;
    logic hi_in;
    logic lo_in;
    logic zhigh_in;
    logic zlow_in;
    logic con_in;
    logic outport_in;
  } reg_load_t;

  typedef struct packed {
    logic inc_pc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
  } misc_strobe_t;

  typedef struct packed {
    bus_drive_t   drive;
    reg_load_t    load;
    misc_strobe_t misc;
    opcode_t      alu_op;
    logic         run;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps ir[31:27] to an instruction class
// and flags encodings that are not defined.
module ctrl_decode
  import cpu_pkg::*;
(
  input  opcode_t      op,
  output instr_class_t cls_c,
  output logic         legal_c
);

  always_comb begin
    cls_c   = CLS_HALT;
    legal_c = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls_c = CLS_ALU;
      OP_ADDI:                       cls_c = CLS_ADDI;
      OP_LD:                         cls_c = CLS_LD;
      OP_ST:                         cls_c = CLS_ST;
      OP_BR:                         cls_c = CLS_BR;
      OP_JR:                         cls_c = CLS_JR;
      OP_IN:                         cls_c = CLS_IN;
      OP_OUT:                        cls_c = CLS_OUT;
      OP_MFHI:                       cls_c = CLS_MFHI;
      OP_NOP:                        cls_c = CLS_NOP;
      OP_HALT:                       cls_c = CLS_HALT;
      default: begin
        cls_c   = CLS_HALT;
        legal_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit for the CPU: fetch in T0-T2, decode in T3, execute in
// T4-T7; strobes are decoded from the registered state.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            Cout,
  output logic            BAout,
  output logic            Rout,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            PCin,
  output logic            Rin,
  output logic            HIin,
  output logic            LOin,
  output logic            ZHighIn,
  output logic            ZLowIn,
  output logic            CONin,
  output logic            OutPortin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic [OPCODE_W-1:0] opcode,
  output logic            run
);

  ctrl_state_t  state_q;
  ctrl_state_t  state_d;
  instr_class_t cls_q;
  opcode_t      op_q;
  ctrl_word_t   cw;

  opcode_t      ir_op;
  instr_class_t dec_cls_c;
  logic         dec_legal_c;
  logic         unused_ir_bits;

  assign ir_op          = ir[IR_W-1 -: OPCODE_W];
  assign unused_ir_bits = ^ir[IR_W-OPCODE_W-1:0];

  ctrl_decode u_decode (
    .op      (ir_op),
    .cls_c   (dec_cls_c),
    .legal_c (dec_legal_c)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold the decoded instruction for T4-T7 so ir is only looked at in T3.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cls_q <= CLS_NOP;
      op_q  <= '0;
    end else if (state_q == ST_T3) begin
      cls_q <= dec_cls_c;
      op_q  <= ir_op;
    end
  end

  always_comb begin
    state_d = state_q;
    cw      = '0;
    cw.run  = 1'b1;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0: begin
        cw.drive.pc_out  = 1'b1;
        cw.load.mar_in   = 1'b1;
        cw.misc.inc_pc   = 1'b1;
        cw.load.zlow_in  = 1'b1;
        state_d          = ST_T1;
      end
      ST_T1: begin
        cw.drive.zlow_out = 1'b1;
        cw.load.pc_in     = 1'b1;
        cw.misc.read      = 1'b1;
        cw.load.mdr_in    = 1'b1;
        state_d           = ST_T2;
      end
      ST_T2: begin
        cw.drive.mdr_out = 1'b1;
        cw.load.ir_in    = 1'b1;
        state_d          = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T0;
        if (!dec_legal_c) begin
          state_d = ST_HALT;
        end else begin
          case (dec_cls_c)
            CLS_ALU, CLS_ADDI: begin
              cw.misc.grb   = 1'b1;
              cw.drive.r_out = 1'b1;
              cw.load.y_in  = 1'b1;
              state_d       = ST_T4;
            end
            CLS_LD, CLS_ST: begin
              cw.misc.grb    = 1'b1;
              cw.drive.ba_out = 1'b1;
              cw.load.y_in   = 1'b1;
              state_d        = ST_T4;
            end
            CLS_BR: begin
              cw.misc.gra    = 1'b1;
              cw.drive.r_out = 1'b1;
              cw.load.con_in = 1'b1;
              state_d        = ST_T4;
            end
            CLS_JR: begin
              cw.misc.gra    = 1'b1;
              cw.drive.r_out = 1'b1;
              cw.load.pc_in  = 1'b1;
            end
            CLS_IN: begin
              cw.drive.inport_out = 1'b1;
              cw.misc.gra         = 1'b1;
              cw.load.r_in        = 1'b1;
            end
            CLS_OUT: begin
              cw.misc.gra        = 1'b1;
              cw.drive.r_out     = 1'b1;
              cw.load.outport_in = 1'b1;
            end
            CLS_MFHI: begin
              cw.drive.hi_out = 1'b1;
              cw.misc.gra     = 1'b1;
              cw.load.r_in    = 1'b1;
            end
            CLS_NOP: state_d = ST_T0;
            default: state_d = ST_HALT;
          endcase
        end
      end
      ST_T4: begin
        state_d = ST_T5;
        case (cls_q)
          CLS_ALU: begin
            cw.misc.grc     = 1'b1;
            cw.drive.r_out  = 1'b1;
            cw.load.zlow_in = 1'b1;
            cw.alu_op       = op_q;
          end
          CLS_ADDI, CLS_LD, CLS_ST: begin
            cw.drive.c_out  = 1'b1;
            cw.load.zlow_in = 1'b1;
            cw.alu_op       = OP_ADD;
          end
          CLS_BR: begin
            cw.drive.pc_out = 1'b1;
            cw.load.y_in    = 1'b1;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T5: begin
        state_d = ST_T0;
        case (cls_q)
          CLS_ALU, CLS_ADDI: begin
            cw.drive.zlow_out = 1'b1;
            cw.misc.gra       = 1'b1;
            cw.load.r_in      = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            cw.drive.zlow_out = 1'b1;
            cw.load.mar_in    = 1'b1;
            state_d           = ST_T6;
          end
          CLS_BR: begin
            cw.drive.c_out  = 1'b1;
            cw.load.zlow_in = 1'b1;
            cw.alu_op       = OP_ADD;
            state_d         = ST_T6;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        state_d = ST_T0;
        case (cls_q)
          CLS_LD: begin
            cw.misc.read   = 1'b1;
            cw.load.mdr_in = 1'b1;
            state_d        = ST_T7;
          end
          CLS_ST: begin
            cw.misc.gra    = 1'b1;
            cw.drive.r_out = 1'b1;
            cw.load.mdr_in = 1'b1;
            state_d        = ST_T7;
          end
          CLS_BR: begin
            cw.drive.zlow_out = 1'b1;
            cw.load.pc_in     = con_ff;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T7: begin
        state_d = ST_T0;
        case (cls_q)
          CLS_LD: begin
            cw.drive.mdr_out = 1'b1;
            cw.misc.gra      = 1'b1;
            cw.load.r_in     = 1'b1;
          end
          CLS_ST:  cw.misc.write = 1'b1;
          default: state_d = ST_T0;
        endcase
      end
      ST_HALT: begin
        cw.run  = 1'b0;
        state_d = ST_HALT;
      end
      default: state_d = ST_RST;
    endcase
  end

  assign PCout     = cw.drive.pc_out;
  assign Zhighout  = cw.drive.zhigh_out;
  assign Zlowout   = cw.drive.zlow_out;
  assign MDRout    = cw.drive.mdr_out;
  assign HIout     = cw.drive.hi_out;
  assign LOout     = cw.drive.lo_out;
  assign InPortout = cw.drive.inport_out;
  assign Cout      = cw.drive.c_out;
  assign BAout     = cw.drive.ba_out;
  assign Rout      = cw.drive.r_out;
  assign MARin     = cw.load.mar_in;
  assign MDRin     = cw.load.mdr_in;
  assign IRin      = cw.load.ir_in;
  assign Yin       = cw.load.y_in;
  assign PCin      = cw.load.pc_in;
  assign Rin       = cw.load.r_in;
  assign HIin      = cw.load.hi_in;
  assign LOin      = cw.load.lo_in;
  assign ZHighIn   = cw.load.zhigh_in;
  assign ZLowIn    = cw.load.zlow_in;
  assign CONin     = cw.load.con_in;
  assign OutPortin = cw.load.outport_in;
  assign IncPC     = cw.misc.inc_pc;
  assign Read      = cw.misc.read;
  assign Write     = cw.misc.write;
  assign Gra       = cw.misc.gra;
  assign Grb       = cw.misc.grb;
  assign Grc       = cw.misc.grc;
  assign opcode    = cw.alu_op;
  assign run       = cw.run;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL: clock  in  1  system clock; all state changes occur on its rising edge.
REQ-002 SHALL: clear  in  1  reset, asynchronous and active-low; clear=0 forces reset state immediately.
REQ-003 SHALL: ir  in  32  instruction register contents; opcode=ir[31:27].
REQ-004 SHALL: con_ff  in  1  branch-condition flag from the datapath CON flip-flop.
REQ-005 SHALL: PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus-drive strobes.
REQ-006 SHALL: MARin, MDRin, IRin, Yin, PCin, Rin, HIin, LOin, ZHighIn, ZLowIn, CONin, OutPortin  out  1 each  register-load strobes.
REQ-007 SHALL: IncPC, Read, Write, Gra, Grb, Grc  out  1 each  PC-increment, memory, and register-select strobes.
REQ-008 SHALL: opcode  out  5  ALU operation select; 00000 whenever not specified below.
REQ-009 SHALL: run  out  1  1 while sequencing, 0 once halted.

Function
REQ-010 SHALL be a Moore machine: every output is decoded from the registered state, with ir[31:27] and con_ff also used where stated; one state per clock.
REQ-011 SHALL have states RST, T0..T7, HALT; any strobe not listed for a state is 0.
REQ-012 SHALL sequence RST -> T0 unconditionally, with all strobes 0 in RST.
REQ-013 SHALL drive the fetch as: T0 PCout MARin IncPC ZLowIn; T1 Zlowout PCin Read MDRin; T2 MDRout IRin; then T2 -> T3.
REQ-014 SHALL decode ir in T3 and continue each instruction as below, returning to T0 after its last listed step.
REQ-015 SHALL implement ALU ops ADD 00011, SUB 00100, AND 00101, OR 00110 as: T3 Grb Rout Yin; T4 Grc Rout ZLowIn opcode=ir[31:27]; T5 Zlowout Gra Rin.
REQ-016 SHALL implement ADDI 01100 as: T3 Grb Rout Yin; T4 Cout ZLowIn opcode=00011; T5 Zlowout Gra Rin.
REQ-017 SHALL implement LD 00000 as: T3 Grb BAout Yin; T4 Cout ZLowIn opcode=00011; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
REQ-018 SHALL implement ST 00010 with LD's T3-T5, then: T6 Gra Rout MDRin (Read=0); T7 Write.
REQ-019 SHALL implement BR 10010 as: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ZLowIn opcode=00011; T6 Zlowout, with PCin=con_ff.
REQ-020 SHALL implement JR 10011 as: T3 Gra Rout PCin.
REQ-021 SHALL implement IN 10101 as T3 InPortout Gra Rin, OUT 10110 as T3 Gra Rout OutPortin, and MFHI 10111 as T3 HIout Gra Rin.
REQ-022 SHALL implement NOP 11010 as T3 with no strobes, then T0.
REQ-023 SHALL enter HALT from T3 on opcode HALT 11011 or any undefined opcode; HALT is absorbing, all strobes 0, run=0.
REQ-024 SHALL never assert Read and Write together, nor more than one bus-drive strobe in any state.
REQ-025 SHALL leave ir unsampled outside T3-T7; changes to ir during T0-T2 have no effect.

Reset
REQ-026 SHALL, on clear=0 in any state (mid-instruction included), asynchronously enter RST, zero all strobes and opcode, and set run=1.
REQ-027 SHALL hold RST while clear=0, then on the first rising edge with clear=1 move to T0, giving one idle cycle before fetch.

Structure
REQ-028 SHALL place the opcode constants and the state enumeration in shared package cpu_pkg, which the datapath ALU also uses.
REQ-029 SHALL be one sequential module; a combinational sub-module, ctrl_decode, SHALL classify ir[31:27] into instruction class and legal/illegal.
REQ-030 SHALL keep the design to 120-400 lines of RTL, with no memory inferred.

Verification
REQ-031 SHALL cover: ir=0x18918000 (ADD R1,R2,R3) -> T3 Grb Rout Yin; T4 Grc Rout ZLowIn opcode=00011; T5 Zlowout Gra Rin; T0 again 6 cycles after the previous T0.
REQ-032 SHALL cover: LD, with clear pulsed low in T5 -> outputs 0 within the same cycle, no Read/Write, and T0 strobes on the second edge after release.
REQ-033 SHALL cover: BR with con_ff=0 -> PCin=0 in T6; with con_ff=1 -> PCin=1 in T6; both return to T0.
REQ-034 SHALL cover: ST -> MDRin=1 with Read=0 in T6, and Write=1 only in T7.
REQ-035 SHALL cover: JR -> 4-cycle instruction with T3 Gra Rout PCin, followed by a normal fetch.
REQ-036 SHALL cover: opcode 11011, and separately 11111 -> HALT, run=0, all strobes 0 for 20 cycles, recovered only by clear.
